binary_multiplier_3bit: RTL and testbench

Unsigned 3-bit × 3-bit array multiplier with a registered 6-bit product and a single-bit valid qualifier. It is a small arithmetic leaf used wherever a narrow exact product is needed. Partial products are summed through a carry-save/ripple full-adder array, then registered. A compile-time option adds an internal pipeline stage.

---
 rtl/mult3_pkg.sv | 20 ++
 rtl/mult3_full_adder.sv | 11 +
 rtl/binary_multiplier_3bit.sv | 106 ++++++++++
 tb/tb_binary_multiplier_3bit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mult3_pkg.sv
// Shared widths and types for the 3x3 unsigned array multiplier.
package mult3_pkg;
    localparam int WIDTH  = 3;
    localparam int PROD_W = 2 * WIDTH;

    typedef logic [PROD_W-1:0] product_t;

    // Carry-save state between the first adder row and the final ripple row.
    // Field names carry the bit weight they contribute to (p0 = weight 1, ...).
    typedef struct packed {
        logic c3;    // weight 16, carry out of the weight-8 half adder
        logic pp22;  // weight 16, A[2]&B[2]
        logic c2;    // weight 8, carry out of the weight-4 full adder
        logic s3;    // weight 8, sum of the weight-8 half adder
        logic c1;    // weight 4, carry out of the weight-2 half adder
        logic s2;    // weight 4, sum of the weight-4 full adder
        logic p1;    // weight 2, final product bit 1
        logic p0;    // weight 1, final product bit 0
    } mid_t;
endpackage

// File: rtl/mult3_full_adder.sv
// One-bit full adder; used as a half adder with cin tied low.
module mult3_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/binary_multiplier_3bit.sv
// Unsigned 3x3 array multiplier with registered 6-bit product and valid.
// Build option: BINARY_MULTIPLIER_3BIT_PIPE_EN inserts a register between the
// carry-save first row and the final ripple row (latency 2 instead of 1).
module binary_multiplier_3bit
    import mult3_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output product_t         P,
    output logic             out_valid
);
`ifdef BINARY_MULTIPLIER_3BIT_PIPE_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif

    logic [WIDTH-1:0][WIDTH-1:0] pp;
    logic [2:0] r1_a, r1_b, r1_ci, r1_s, r1_c;
    mid_t       mid_d, mid_use;
    logic [2:0] r2_s, r2_c;
    product_t   prod_d;
    logic       load_out;
    logic [STAGES:1] vld_pipe;

    // Partial products: row i is A gated by B[i].
    always_comb begin
        for (int i = 0; i < WIDTH; i++)
            for (int j = 0; j < WIDTH; j++)
                pp[i][j] = A[j] & B[i];
    end

    // First row: compress weights 2, 4 and 8 without carry propagation.
    always_comb begin
        r1_a  = {pp[1][2], pp[0][2], pp[0][1]};
        r1_b  = {pp[2][1], pp[1][1], pp[1][0]};
        r1_ci = {1'b0,     pp[2][0], 1'b0};
    end

    mult3_full_adder u_row1 [2:0] (
        .a    (r1_a),
        .b    (r1_b),
        .cin  (r1_ci),
        .sum  (r1_s),
        .cout (r1_c)
    );

    // Collect the carry-save result of the first row.
    always_comb begin
        mid_d      = '0;
        mid_d.p0   = pp[0][0];
        mid_d.p1   = r1_s[0];
        mid_d.s2   = r1_s[1];
        mid_d.c1   = r1_c[0];
        mid_d.s3   = r1_s[2];
        mid_d.c2   = r1_c[1];
        mid_d.pp22 = pp[2][2];
        mid_d.c3   = r1_c[2];
    end

`ifdef BINARY_MULTIPLIER_3BIT_PIPE_EN
    mid_t mid_q;

    // Mid-array register; only loads on accepted operands so idle inputs are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        mid_q <= '0;
        else if (in_valid) mid_q <= mid_d;
    end

    // Valid travels alongside the data through both stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[1], in_valid};
    end

    assign mid_use  = mid_q;
    assign load_out = vld_pipe[1];
`else
    // Single-stage valid: follows in_valid one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= in_valid;
    end

    assign mid_use  = mid_d;
    assign load_out = in_valid;
`endif

    // Final ripple row: weights 4, 8, 16; its last carry is product bit 5.
    mult3_full_adder u_rip0 (.a(mid_use.s2),   .b(mid_use.c1), .cin(1'b0),    .sum(r2_s[0]), .cout(r2_c[0]));
    mult3_full_adder u_rip1 (.a(mid_use.s3),   .b(mid_use.c2), .cin(r2_c[0]), .sum(r2_s[1]), .cout(r2_c[1]));
    mult3_full_adder u_rip2 (.a(mid_use.pp22), .b(mid_use.c3), .cin(r2_c[1]), .sum(r2_s[2]), .cout(r2_c[2]));

    assign prod_d = {r2_c[2], r2_s, mid_use.p1, mid_use.p0};

    // Output register holds its value on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        P <= '0;
        else if (load_out) P <= prod_d;
    end

    assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_binary_multiplier_3bit.sv
// Self-checking bench for binary_multiplier_3bit (either latency build).
module tb_binary_multiplier_3bit;
`ifdef BINARY_MULTIPLIER_3BIT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] A = '0;
    logic [2:0] B = '0;
    logic [5:0] P;
    logic       out_valid;

    binary_multiplier_3bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .P         (P),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic [5:0] p;
    } vec_t;

    vec_t stream[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic seen_valid;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive every entry of stream back-to-back and check each result LAT edges later.
    task automatic run_stream(input string tag);
        int k;
        for (int c = 0; c < stream.size() + LAT - 1; c++) begin
            @(negedge clk);
            if (c < stream.size()) begin
                in_valid = 1'b1;
                A = stream[c].a;
                B = stream[c].b;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            k = c - (LAT - 1);
            if (k >= 0) begin
                chk($sformatf("%s valid %0d*%0d", tag, stream[k].a, stream[k].b), {7'd0, out_valid}, 8'd1);
                chk($sformatf("%s P %0d*%0d", tag, stream[k].a, stream[k].b), {2'd0, P}, {2'd0, stream[k].p});
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk($sformatf("%s valid drops", tag), {7'd0, out_valid}, 8'd0);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;

        // Reset state, no clock edge needed
        #1;
        chk("reset P", {2'd0, P}, 8'd0);
        chk("reset valid", {7'd0, out_valid}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed products, hand-computed
        tbl.push_back('{3'd0, 3'd0, 6'b000000});
        tbl.push_back('{3'd1, 3'd2, 6'b000010});
        tbl.push_back('{3'd3, 3'd2, 6'b000110});
        tbl.push_back('{3'd7, 3'd7, 6'b110001});
        tbl.push_back('{3'd3, 3'd5, 6'b001111});
        tbl.push_back('{3'd1, 3'd6, 6'b000110});
        tbl.push_back('{3'd4, 3'd6, 6'b011000});
        tbl.push_back('{3'd5, 3'd3, 6'b001111});
        stream = tbl;
        run_stream("dir");

        // Hold: last accepted pair was 5*3; idle input changes must not reach P
        @(negedge clk);
        in_valid = 1'b0;
        A = 3'd7;
        B = 3'd7;
        repeat (LAT + 2) @(posedge clk);
        #1;
        chk("hold P", {2'd0, P}, 8'd15);
        chk("hold valid", {7'd0, out_valid}, 8'd0);

        // Asynchronous reset while P is nonzero
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset P", {2'd0, P}, 8'd0);
        chk("async reset valid", {7'd0, out_valid}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive back-to-back sweep
        stream.delete();
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++) begin
                v.a = 3'(a);
                v.b = 3'(b);
                v.p = 6'(a * b);
                stream.push_back(v);
            end
        run_stream("exh");

        // Reset mid-flight: accept 7*7, reset before its result edge
        @(negedge clk);
        in_valid = 1'b1;
        A = 3'd7;
        B = 3'd7;
        repeat (LAT - 1) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midflight reset P", {2'd0, P}, 8'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        repeat (LAT + 3) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid = 1'b1;
        end
        chk("midflight no valid", {7'd0, seen_valid}, 8'd0);
        chk("midflight P", {2'd0, P}, 8'd0);

        // Recovery after reset: one isolated product
        stream.delete();
        stream.push_back('{3'd6, 3'd7, 6'b101010});
        run_stream("post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
